// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver (5..9 data bits, none/odd/even parity,
//            1 or 2 stop bits) with 3-sample majority voting and receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BIT_RATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 uart_valid,
    input  logic                 uart_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int c_BIT_CNT = CLK_FREQ / BIT_RATE;
    localparam int c_HALF    = c_BIT_CNT / 2;
    localparam int c_CW      = $clog2(c_BIT_CNT);
    localparam int c_BW      = $clog2(DATA_BITS);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_EW      = DATA_BITS + 2;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_BIT_CNT - 1);
    localparam logic [c_CW-1:0] c_SMP0     = c_CW'(c_HALF - 1);
    localparam logic [c_CW-1:0] c_SMP1     = c_CW'(c_HALF);
    localparam logic [c_CW-1:0] c_DEC      = c_CW'(c_HALF + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_BITS - 1);
    localparam logic            c_STOP_LAST = (STOP_BITS == 2);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_PAR   = 3'd3;
    localparam logic [2:0] c_S_STOP  = 3'd4;

    // Synchroniser and edge flop idle high so reset never looks like a start bit
    logic r_sync1, r_rxd_s, r_rxd_d;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
            r_rxd_d <= r_rxd_s;
        end
    end

    assign w_fall = r_rxd_d & ~r_rxd_s;

    logic [2:0]           r_state, w_state_nxt;
    logic [c_CW-1:0]      r_cnt, w_cnt_nxt;
    logic [c_BW-1:0]      r_bit, w_bit_nxt;
    logic                 r_stop, w_stop_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 r_smp0, r_smp1;
    logic                 w_vote, w_dec, w_last, w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp0 <= 1'b1;
            r_smp1 <= 1'b1;
        end else begin
            if (r_cnt == c_SMP0) r_smp0 <= r_rxd_s;
            if (r_cnt == c_SMP1) r_smp1 <= r_rxd_s;
        end
    end

    assign w_vote = (r_smp0 & r_smp1) | (r_smp0 & r_rxd_s) | (r_smp1 & r_rxd_s);
    assign w_dec  = (r_cnt == c_DEC);
    assign w_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_stop  <= w_stop_nxt;
            r_shift <= w_shift_nxt;
            r_ferr  <= w_ferr_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? '0 : r_cnt + c_CW'(1);
        w_bit_nxt   = r_bit;
        w_stop_nxt  = r_stop;
        w_shift_nxt = r_shift;
        w_ferr_nxt  = r_ferr;
        w_perr_nxt  = r_perr;
        w_push      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = c_S_START;
                    w_bit_nxt   = '0;
                    w_stop_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                    w_perr_nxt  = 1'b0;
                end
            end
            c_S_START: begin
                if (w_dec && w_vote) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_last) begin
                    w_state_nxt = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_dec) w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                if (w_last) begin
                    if (r_bit == c_BIT_LAST)
                        w_state_nxt = (PARITY != 0) ? c_S_PAR : c_S_STOP;
                    else
                        w_bit_nxt = r_bit + c_BW'(1);
                end
            end
            c_S_PAR: begin
                // Even: total ones incl. parity bit must be even; odd flips it
                if (w_dec) w_perr_nxt = (^{r_shift, w_vote}) ^ (PARITY == 1);
                if (w_last) w_state_nxt = c_S_STOP;
            end
            c_S_STOP: begin
                if (w_dec) begin
                    if (!w_vote) w_ferr_nxt = 1'b1;
                    // Leave half a bit early so back-to-back start bits are caught
                    if (r_stop == c_STOP_LAST) begin
                        w_push      = 1'b1;
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                if (w_last) w_stop_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state != c_S_IDLE);

    // Receive FIFO: {data, frame_err, parity_err} per entry
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_overrun;
    logic            w_pop, w_full, w_wr;
    logic [c_EW-1:0] w_entry, w_head;

    assign w_entry = {r_shift, w_ferr_nxt, r_perr};
    assign w_pop   = (r_count != '0) & uart_ready;
    assign w_full  = (r_count == c_FULL);
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push & w_full & ~w_pop;
            if (w_wr)  r_wptr <= r_wptr + c_AW'(1);
            if (w_pop) r_rptr <= r_rptr + c_AW'(1);
            r_count <= r_count + {{c_AW{1'b0}}, w_wr} - {{c_AW{1'b0}}, w_pop};
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign uart_valid = (r_count != '0);
    assign uart_data  = uart_valid ? w_head[c_EW-1:2] : '0;
    assign frame_err  = uart_valid & w_head[1];
    assign parity_err = uart_valid & w_head[0];
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param, three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;
    // Per-instance configuration: 0 = defaults 8N1, 1 = 8E1, 2 = 7O2 depth 2
    int bc  [3] = '{434, 16, 12};
    int hf  [3] = '{217, 8, 6};
    int db  [3] = '{8, 8, 7};
    int par [3] = '{0, 2, 1};
    int sb  [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;
    logic [2:0] ready = 3'b000;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] valid, ferr, perr, ovr, busy;

    int checks = 0;
    int errors = 0;
    int ovr_cyc [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_param u_dut0 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .uart_data(d0), .uart_valid(valid[0]),
        .uart_ready(ready[0]), .frame_err(ferr[0]), .parity_err(perr[0]),
        .overrun(ovr[0]), .busy(busy[0]));

    uart_rx_param #(.CLK_FREQ(1843200), .BIT_RATE(115200), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .uart_data(d1), .uart_valid(valid[1]),
        .uart_ready(ready[1]), .frame_err(ferr[1]), .parity_err(perr[1]),
        .overrun(ovr[1]), .busy(busy[1]));

    uart_rx_param #(.CLK_FREQ(1382400), .BIT_RATE(115200), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .uart_data(d2), .uart_valid(valid[2]),
        .uart_ready(ready[2]), .frame_err(ferr[2]), .parity_err(perr[2]),
        .overrun(ovr[2]), .busy(busy[2]));

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) if (ovr[k] === 1'b1) ovr_cyc[k]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int nbits(input int idx);
        return 1 + db[idx] + ((par[idx] != 0) ? 1 : 0) + sb[idx];
    endfunction

    function automatic logic [8:0] dat(input int idx);
        case (idx)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return {2'b00, d2};
        endcase
    endfunction

    // Line bits in transmit order; pflip inverts the correct parity bit
    function automatic logic [15:0] make_frame(input int idx, input logic [8:0] data,
                                               input logic pflip, input logic [1:0] stops);
        logic [15:0] f = '1;
        logic        pb = 1'b0;
        int          p = 1;
        f[0] = 1'b0;
        for (int i = 0; i < db[idx]; i++) begin
            f[p] = data[i];
            pb   = pb ^ data[i];
            p++;
        end
        if (par[idx] != 0) begin
            if (par[idx] == 1) pb = ~pb;
            f[p] = pb ^ pflip;
            p++;
        end
        for (int i = 0; i < sb[idx]; i++) begin
            f[p] = stops[i];
            p++;
        end
        return f;
    endfunction

    // Expected FIFO entry {data, frame_err, parity_err} from the line bits
    function automatic logic [10:0] model(input int idx, input logic [15:0] f);
        logic [8:0] d = '0;
        logic       fe = 1'b0;
        logic       pe = 1'b0;
        int         p = 1;
        int         ones;
        for (int i = 0; i < db[idx]; i++) begin
            d[i] = f[p];
            p++;
        end
        if (par[idx] != 0) begin
            ones = $countones(d) + (f[p] ? 1 : 0);
            pe   = (par[idx] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            p++;
        end
        for (int i = 0; i < sb[idx]; i++) begin
            if (f[p] == 1'b0) fe = 1'b1;
            p++;
        end
        return {d, fe, pe};
    endfunction

    // Drives one frame; cycle numbers are counted from the falling edge (cycle 0)
    task automatic xfer(input int idx, input logic [15:0] f, output int t_bh, output int t_bl,
                        output int t_v, output int n_v, output int t_o, output logic [10:0] got);
        int nb = nbits(idx);
        t_bh = -1; t_bl = -1; t_v = -1; n_v = 0; t_o = -1; got = '1;
        for (int c = 0; c < nb * bc[idx]; c++) begin
            rxd[idx] = f[c / bc[idx]];
            @(negedge clk);
            if (busy[idx] === 1'b1 && t_bh < 0) t_bh = c + 1;
            if (t_bh >= 0 && busy[idx] === 1'b0 && t_bl < 0) t_bl = c + 1;
            if (valid[idx] === 1'b1) begin
                n_v++;
                if (t_v < 0) begin
                    t_v = c + 1;
                    got = {dat(idx), ferr[idx], perr[idx]};
                end
            end
            if (ovr[idx] === 1'b1 && t_o < 0) t_o = c + 1;
        end
    endtask

    task automatic pop_check(input int idx, input logic [10:0] e_entry, input string tag);
        int w = 0;
        while (valid[idx] !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " pop_valid"}, 32'(valid[idx]), 1);
        chk({tag, " pop_entry"}, 32'({dat(idx), ferr[idx], perr[idx]}), 32'(e_entry));
        ready[idx] = 1'b1;
        @(negedge clk);
        ready[idx] = 1'b0;
    endtask

    // One isolated frame into an empty FIFO: timing, entry, pop, empty again
    task automatic frame(input int idx, input logic [8:0] data, input logic pflip,
                         input logic [1:0] stops, input string tag, output logic [10:0] got);
        logic [15:0] f = make_frame(idx, data, pflip, stops);
        logic [10:0] e_entry = model(idx, f);
        int d1 = 3 + (nbits(idx) - 1) * bc[idx] + hf[idx] + 2;
        int t_bh, t_bl, t_v, n_v, t_o;
        ready[idx] = 1'b0;
        xfer(idx, f, t_bh, t_bl, t_v, n_v, t_o, got);
        rxd[idx] = 1'b1;
        chk({tag, " busy_rise"}, t_bh, 3);
        chk({tag, " busy_fall"}, t_bl, d1);
        chk({tag, " valid_cycle"}, t_v, d1);
        chk({tag, " no_overrun"}, t_o, -1);
        chk({tag, " entry"}, 32'(got), 32'(e_entry));
        pop_check(idx, e_entry, tag);
        chk({tag, " empty_after_pop"}, 32'(valid[idx]), 0);
        repeat (bc[idx]) @(negedge clk);
    endtask

    initial begin
        logic [10:0] got;
        logic [15:0] f;
        logic [8:0]  rd;
        int t_bh, t_bl, t_v, n_v, t_o, o0, nb_cnt, nv_cnt, d1_0;

        d1_0 = 3 + 9 * 434 + 217 + 2;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_valid%0d", k), 32'(valid[k]), 0);
            chk($sformatf("reset_busy%0d", k), 32'(busy[k]), 0);
            chk($sformatf("reset_flags%0d", k), 32'({ferr[k], perr[k], ovr[k]}), 0);
            chk($sformatf("reset_data%0d", k), 32'(dat(k)), 0);
        end

        // 8N1 0x55 with ready held high: one-cycle valid at D+1
        ready[0] = 1'b1;
        xfer(0, make_frame(0, 9'h055, 1'b0, 2'b11), t_bh, t_bl, t_v, n_v, t_o, got);
        ready[0] = 1'b0;
        chk("t1 busy_rise", t_bh, 3);
        chk("t1 busy_fall", t_bl, d1_0);
        chk("t1 valid_cycle", t_v, d1_0);
        chk("t1 valid_len", n_v, 1);
        chk("t1 entry", 32'(got), 32'({9'h055, 2'b00}));
        repeat (434) @(negedge clk);

        // Even parity: 0xA3 needs parity bit 0; flipped bit reports parity_err
        frame(1, 9'h0A3, 1'b1, 2'b11, "par_bad", got);
        chk("par_bad flag", 32'(got), 32'({9'h0A3, 2'b01}));
        frame(1, 9'h0A3, 1'b0, 2'b11, "par_ok", got);
        chk("par_ok flag", 32'(got), 32'({9'h0A3, 2'b00}));

        // Stop bit driven low, then a clean frame
        frame(0, 9'h00F, 1'b0, 2'b00, "stop_bad", got);
        chk("stop_bad flag", 32'(got), 32'({9'h00F, 2'b10}));
        frame(0, 9'h03C, 1'b0, 2'b11, "after_stop_bad", got);

        // 100-cycle low pulse is rejected as a glitch
        nb_cnt = 0;
        nv_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            rxd[0] = (c < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy[0] === 1'b1) nb_cnt++;
            if (valid[0] === 1'b1) nv_cnt++;
        end
        chk("glitch busy_cycles", nb_cnt, 219);
        chk("glitch no_push", nv_cnt, 0);
        frame(0, 9'h07E, 1'b0, 2'b11, "after_glitch", got);

        // Five back-to-back frames into a 4-deep FIFO with ready low
        o0 = ovr_cyc[0];
        for (int i = 1; i <= 5; i++) begin
            xfer(0, make_frame(0, 9'(i), 1'b0, 2'b11), t_bh, t_bl, t_v, n_v, t_o, got);
            if (i == 4) chk("ovr none_before_5", ovr_cyc[0] - o0, 0);
        end
        chk("ovr pulse_count", ovr_cyc[0] - o0, 1);
        chk("ovr cycle", t_o, d1_0);
        for (int i = 1; i <= 4; i++) pop_check(0, {9'(i), 2'b00}, $sformatf("drain%0d", i));
        chk("drain empty", 32'(valid[0]), 0);
        repeat (434) @(negedge clk);

        // Preload one entry, then reset during data bit 4 of another frame
        xfer(0, make_frame(0, 9'h099, 1'b0, 2'b11), t_bh, t_bl, t_v, n_v, t_o, got);
        chk("preload entry", 32'(got), 32'({9'h099, 2'b00}));
        f = make_frame(0, 9'h0AB, 1'b0, 2'b11);
        for (int c = 0; c < 5 * 434 + 100; c++) begin
            rxd[0] = f[c / 434];
            @(negedge clk);
        end
        rst = 1'b1;
        rxd[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst valid", 32'(valid[0]), 0);
        chk("midrst busy", 32'(busy[0]), 0);
        chk("midrst data", 32'(dat(0)), 0);
        repeat (434) @(negedge clk);
        frame(0, 9'h0C5, 1'b0, 2'b11, "after_rst", got);

        // Randomised 7O2 frames with occasional parity and stop faults
        for (int i = 0; i < 16; i++) begin
            rd = 9'($urandom_range(0, 127));
            frame(2, rd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ?
                  2'($urandom_range(0, 3)) : 2'b11, $sformatf("rand%0d", i), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the team's fixed 8N1 receiver. It supports configurable data width, parity mode and stop-bit count, and uses 3-sample majority voting with start-bit glitch rejection. It reports framing, parity and overrun errors. Received frames are buffered in a small FIFO behind a valid/ready interface, so downstream logic (command parser, loopback TX) may stall without losing bytes.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BIT_RATE, 115200: baud rate. Derived: BIT_CNT = CLK_FREQ/BIT_RATE (integer, must be ≥ 8); HALF = BIT_CNT/2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries, power of 2, ≥ 2.
- clk, input, 1: single system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- rxd, input, 1: asynchronous serial line, idle high.
- uart_data, output, DATA_BITS: data of the FIFO head entry, LSB = first received data bit.
- uart_valid, output, 1: FIFO not empty.
- uart_ready, input, 1: consumer accepts the head entry when uart_valid && uart_ready.
- frame_err, output, 1: head entry's stop-bit error flag, qualified by uart_valid.
- parity_err, output, 1: head entry's parity error flag, qualified by uart_valid; always 0 when PARITY = 0.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- busy, output, 1: FSM not in IDLE.

## Operation
- Reset values:
  - uart_data = 0; uart_valid, frame_err, parity_err, overrun and busy = 0.
  - FIFO empty; FSM in IDLE; bit and clock counters at 0.
  - Synchroniser flops = 1, so no false start is detected after reset.
- rxd passes through a 2-flop synchroniser giving rxd_s. A third flop holds rxd_s_d. A fall is rxd_s_d = 1 and rxd_s = 0.
- The clock counter cnt runs 0..BIT_CNT-1 within each bit and restarts at 0 on every bit boundary and on leaving IDLE.
- Sampling: rxd_s is sampled at cnt = HALF-1, HALF and HALF+1. The bit value is the majority of the three, decided at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a fall moves the FSM to START with cnt = 0.
  - START: if the majority vote is 1, the start is treated as a glitch and the FSM returns to IDLE at the decision cycle. Otherwise the FSM goes to DATA at cnt = BIT_CNT-1.
  - DATA: shifts DATA_BITS bits LSB-first. After the last bit it goes to PARITY if PARITY ≠ 0, else to STOP.
  - PARITY: computes the expected bit (odd or even over the data bits) and latches parity_err on mismatch.
  - STOP: on each stop bit, a majority vote of 0 sets the frame error.
    - With STOP_BITS = 2, the first stop bit runs the full BIT_CNT and the second ends early.
    - At the decision cycle of the final stop bit, the frame is pushed and the FSM returns to IDLE immediately (half-bit early resynchronisation for back-to-back frames).
- A frame with a stop error is still pushed, with frame_err = 1 and the data as received.
- FIFO: each entry holds {data, frame_err, parity_err}; pointers wrap modulo FIFO_DEPTH and an occupancy count tracks full and empty.
  - Pop: occurs when uart_valid && uart_ready.
  - Push when full: the frame is dropped and overrun pulses for one cycle.
  - Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, no overrun, occupancy unchanged.
  - Push and pop in the same cycle while empty: the push only is performed; there is no fall-through.
- Reset mid-frame: the partial frame is discarded, FIFO contents are lost, all state returns to reset values.

## Timing
- Let E be the first cycle in START with cnt = 0. E is 3 cycles after the rxd falling edge: 2 synchroniser flops plus the edge flop.
- F = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits per frame.
- Final decision cycle D = E + (F-1)·BIT_CNT + HALF + 1.
- The FIFO write is registered at D; uart_valid and the new head entry are visible from D+1.
- A pop takes effect on the next edge. With occupancy > 1, the next head entry is visible in the cycle after the pop.
- overrun is high only in cycle D+1 of the dropped frame.
- busy goes high at E and low at D+1; a new fall is accepted from D+1.
- A glitch returns the FSM to IDLE at E + HALF + 1; busy goes low the following cycle.

## Test plan
- Defaults (BIT_CNT = 434, HALF = 217), 8N1, frame 0x55, ready held 1 → uart_valid for 1 cycle at D+1, uart_data = 0x55, frame_err = 0, parity_err = 0.
- PARITY = 2, data 0xA3 with the parity bit sent as 1 (correct value 0) → entry 0xA3 with parity_err = 1; resend with parity bit 0 → parity_err = 0.
- 8N1, data 0x0F with the stop bit driven 0 → entry 0x0F with frame_err = 1; the next correct frame 0x3C is received cleanly.
- rxd low for 100 cycles then high → busy pulses, no FIFO push, no errors; a following 0x7E frame is received correctly.
- ready = 0, five back-to-back frames 0x01..0x05, FIFO_DEPTH = 4 → overrun pulses once, after frame 5; popping yields 0x01, 0x02, 0x03, 0x04, then uart_valid = 0.
- rst asserted during data bit 4 of a frame, released, then frame 0xC5 sent → no entry from the aborted frame; the FIFO holds only 0xC5.
